// File: rtl/diag_aggregator_pkg.sv
// -----------------------------------------------------------------------------
// diag_aggregator_pkg
//   Shared types and helpers for the systolic wavefront collector. The diagonal
//   geometry functions are also used by the PE-array drain sequencer, so they
//   take N as an argument instead of relying on a package constant.
//   No ports (package).
// -----------------------------------------------------------------------------
package diag_aggregator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    // Number of meaningful lanes on anti-diagonal k of an n x n matrix.
    function automatic int diag_len(input int k, input int n);
        if (k + 1 < 2 * n - 1 - k) return k + 1;
        return 2 * n - 1 - k;
    endfunction

    // Row of lane 0 on anti-diagonal k.
    function automatic int diag_base(input int k, input int n);
        if (k > n - 1) return k - n + 1;
        return 0;
    endfunction

endpackage

// File: rtl/diag_aggregator_if.sv
// -----------------------------------------------------------------------------
// diag_aggregator_if
//   Wavefront input stream and row output stream of the collector.
//   in_valid/in_ready/in_data : one anti-diagonal per beat, lane j at [j*W +: W]
//   out_valid/out_ready/out_data/out_row/out_last : one row (or column) per beat
//   master : the PE drain / writeback side; slave : the collector.
// -----------------------------------------------------------------------------
interface diag_aggregator_if #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int RW = $clog2(N)
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic [RW-1:0]  out_row;
    logic           out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row, out_last
    );
endinterface

// File: rtl/agg_diag_map.sv
// -----------------------------------------------------------------------------
// agg_diag_map
//   Combinational lane map for anti-diagonal k: lane j (j < L(k)) targets
//   M[b+j][k-b-j]. Disabled lanes report index 0.
//   k_i   : diagonal index
//   we_o  : per-lane write enable
//   row_o : per-lane row index
//   col_o : per-lane column index
// -----------------------------------------------------------------------------
module agg_diag_map
    import diag_aggregator_pkg::*;
#(
    parameter int N  = 4,
    parameter int KW = $clog2(2 * N - 1),
    parameter int RW = $clog2(N)
) (
    input  logic [KW-1:0]          k_i,
    output logic [N-1:0]           we_o,
    output logic [N-1:0][RW-1:0]   row_o,
    output logic [N-1:0][RW-1:0]   col_o
);
    int k_int;
    int len_int;
    int base_int;

    assign k_int    = int'(k_i);
    assign len_int  = diag_len(k_int, N);
    assign base_int = diag_base(k_int, N);

    for (genvar j = 0; j < N; j++) begin : g_lane
        assign we_o[j]  = (j < len_int);
        assign row_o[j] = we_o[j] ? RW'(base_int + j) : '0;
        assign col_o[j] = we_o[j] ? RW'(k_int - base_int - j) : '0;
    end
endmodule

// File: rtl/diag_aggregator.sv
// -----------------------------------------------------------------------------
// diag_aggregator
//   Collects 2N-1 anti-diagonal beats into an N x N buffer, then streams the
//   matrix out one row (or column when transposed) per valid/ready beat.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : arms a collection (honoured only in IDLE)
//   transpose  : sampled with an accepted start (ignored if TRANSPOSE_EN=0)
//   busy       : high in COLLECT or DRAIN
//   bus        : wavefront input and row output streams (slave side)
// -----------------------------------------------------------------------------
module diag_aggregator
    import diag_aggregator_pkg::*;
#(
    parameter int N            = 4,
    parameter int W            = 32,
    parameter int TRANSPOSE_EN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             transpose,
    output logic             busy,
    diag_aggregator_if.slave bus
);
    localparam int              KW     = $clog2(2 * N - 1);
    localparam int              RW     = $clog2(N);
    localparam logic [KW-1:0]   K_LAST = KW'(2 * N - 2);
    localparam logic [RW-1:0]   R_LAST = RW'(N - 1);

    state_e                     state_q;
    logic [KW-1:0]              k_q;
    logic [RW-1:0]              row_q;
    logic                       tr_q;
    logic                       busy_q;
    logic                       out_valid_q;
    logic                       out_last_q;
    logic [N*W-1:0]             out_data_q;
    logic [N-1:0][N-1:0][W-1:0] mem_q;      // [row][col]

    logic [N-1:0]               lane_we;
    logic [N-1:0][RW-1:0]       lane_row;
    logic [N-1:0][RW-1:0]       lane_col;

    logic                       in_fire;
    logic                       out_fire;
    logic                       in_done;
    logic                       out_done;
    logic [RW-1:0]              row_d;
    logic [N*W-1:0]             data_d;

    agg_diag_map #(.N(N), .KW(KW), .RW(RW)) u_map (
        .k_i   (k_q),
        .we_o  (lane_we),
        .row_o (lane_row),
        .col_o (lane_col)
    );

    assign in_fire  = (state_q == COLLECT) && bus.in_valid;
    assign out_fire = out_valid_q && bus.out_ready;
    assign in_done  = in_fire && (k_q == K_LAST);
    assign out_done = out_fire && (row_q == R_LAST);

    // Next row to present. Row 0 is loaded on the final diagonal beat straight
    // from the buffer: that beat only writes M[N-1][N-1], which lies outside
    // row 0 and column 0 for N >= 2, so the buffer already holds it completely.
    always_comb begin
        row_d  = in_done ? '0 : row_q + RW'(1);
        data_d = '0;
        for (int c = 0; c < N; c++) begin
            data_d[c*W +: W] = tr_q ? mem_q[c][row_d] : mem_q[row_d][c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            row_q       <= '0;
            tr_q        <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            mem_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= COLLECT;
                        tr_q    <= (TRANSPOSE_EN != 0) && transpose;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (in_fire) begin
                        for (int j = 0; j < N; j++) begin
                            if (lane_we[j]) begin
                                mem_q[lane_row[j]][lane_col[j]] <= bus.in_data[j*W +: W];
                            end
                        end
                        if (in_done) begin
                            // k stays at its terminal value until the next start.
                            state_q     <= DRAIN;
                            row_q       <= '0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                            out_data_q  <= data_d;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (out_done) begin
                            state_q     <= IDLE;
                            row_q       <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            busy_q      <= 1'b0;
                        end else begin
                            row_q      <= row_d;
                            out_last_q <= (row_d == R_LAST);
                            out_data_q <= data_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_row   = row_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_diag_aggregator.sv
// -----------------------------------------------------------------------------
// tb_diag_aggregator
//   Directed bench for the wavefront collector. Instance A: N=4, W=32 with
//   transpose honoured; instance B: N=8, W=16. The expected matrix is the
//   closed form M[r][c] = off + 0x100*(r+1) + (c+1); per-instance monitors
//   compare every presented row against it.
// -----------------------------------------------------------------------------
module tb_diag_aggregator;
    localparam int NA = 4;
    localparam int WA = 32;
    localparam int NB = 8;
    localparam int WB = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, tr_a, busy_a;
    logic start_b, tr_b, busy_b;

    int checks = 0;
    int errors = 0;

    int off_a, off_b;
    int idx_a, idx_b;
    int done_a, done_b;
    int mode_a, cyc_a;
    bit tr_model_a, stall_a;

    diag_aggregator_if #(.N(NA), .W(WA)) ifa ();
    diag_aggregator_if #(.N(NB), .W(WB)) ifb ();

    diag_aggregator #(.N(NA), .W(WA), .TRANSPOSE_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .transpose(tr_a), .busy(busy_a), .bus(ifa)
    );
    diag_aggregator #(.N(NB), .W(WB), .TRANSPOSE_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .transpose(tr_b), .busy(busy_b), .bus(ifb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] elem(input int off, input int r, input int c);
        return 32'(off + 256 * (r + 1) + (c + 1));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            idx_a   = 0;
            stall_a = 0;
        end else begin
            if (stall_a) chk("A out_valid held in stall", ifa.out_valid, 1);
            if (ifa.out_valid) begin
                for (int c = 0; c < NA; c++)
                    chk("A out_data", ifa.out_data[c*WA +: WA],
                        tr_model_a ? elem(off_a, c, idx_a) : elem(off_a, idx_a, c));
                chk("A out_row", ifa.out_row, idx_a);
                chk("A out_last", ifa.out_last, idx_a == NA - 1);
                chk("A in_ready in drain", ifa.in_ready, 0);
                stall_a = !ifa.out_ready;
                if (ifa.out_ready) begin
                    if (idx_a == NA - 1) begin idx_a = 0; done_a++; end
                    else idx_a++;
                end
            end else begin
                stall_a = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            idx_b = 0;
        end else if (ifb.out_valid) begin
            for (int c = 0; c < NB; c++)
                chk("B out_data", ifb.out_data[c*WB +: WB], 16'(elem(off_b, idx_b, c)));
            chk("B out_row", ifb.out_row, idx_b);
            chk("B out_last", ifb.out_last, idx_b == NB - 1);
            chk("B in_ready in drain", ifb.in_ready, 0);
            if (ifb.out_ready) begin
                if (idx_b == NB - 1) begin idx_b = 0; done_b++; end
                else idx_b++;
            end
        end
    end

    // out_ready: mode 0 = always ready, mode 1 = repeating 1,0,0,1
    initial begin
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc_a++;
            ifa.out_ready = (mode_a == 0) || (cyc_a % 4 == 0) || (cyc_a % 4 == 3);
        end
    end

    // ---------------- stimulus tasks (enter/leave at posedge+1) ----------------
    task automatic start_a_t(input bit t);
        start_a = 1'b1; tr_a = t; tr_model_a = t;
        @(posedge clk); #1;
        start_a = 1'b0; tr_a = 1'b0;
        chk("A busy after start", busy_a, 1);
        chk("A in_ready after start", ifa.in_ready, 1);
    endtask

    task automatic send_a(input int gap, input bit garbage, input int poke_k, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            int b, len, t;
            logic [NA*WA-1:0] d;
            b   = (k > NA - 1) ? k - NA + 1 : 0;
            len = (k + 1 < 2 * NA - 1 - k) ? k + 1 : 2 * NA - 1 - k;
            for (int j = 0; j < NA; j++)
                d[j*WA +: WA] = (j < len) ? elem(off_a, b + j, k - b - j)
                                          : (garbage ? 32'hDEADBEEF : 32'h0);
            ifa.in_data = d; ifa.in_valid = 1'b1; t = 0;
            do begin
                @(negedge clk);
                chk("A out_valid low in collect", ifa.out_valid, 0);
                t++;
            end while (!ifa.in_ready && t < 50);
            chk("A diagonal accepted", ifa.in_ready, 1);
            @(posedge clk); #1;
            ifa.in_valid = 1'b0;
            ifa.in_data  = {NA{32'hDEADBEEF}};
            if (k == 2 * NA - 2) begin
                @(negedge clk);
                chk("A out_valid after last diagonal", ifa.out_valid, 1);
                chk("A in_ready after last diagonal", ifa.in_ready, 0);
            end else begin
                if (k == poke_k) begin
                    start_a = 1'b1; tr_a = 1'b1;
                    @(posedge clk); #1;
                    start_a = 1'b0; tr_a = 1'b0;
                    chk("A busy after collect poke", busy_a, 1);
                end
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic wait_done_a(input bit poke);
        int d0, t;
        d0 = done_a; t = 0;
        if (poke) begin
            @(posedge clk); #1;
            start_a = 1'b1; tr_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0; tr_a = 1'b0;
        end
        while (done_a == d0 && t < 100) begin @(negedge clk); t++; end
        chk("A drain completes", done_a != d0, 1);
        @(posedge clk); #1;
        chk("A busy after drain", busy_a, 0);
        chk("A in_ready after drain", ifa.in_ready, 0);
        chk("A out_valid after drain", ifa.out_valid, 0);
    endtask

    task automatic chk_idle_a();
        chk("A rst busy", busy_a, 0);
        chk("A rst in_ready", ifa.in_ready, 0);
        chk("A rst out_valid", ifa.out_valid, 0);
        chk("A rst out_last", ifa.out_last, 0);
        chk("A rst out_row", ifa.out_row, 0);
        chk("A rst out_data nonzero", |ifa.out_data, 0);
    endtask

    task automatic send_b();
        for (int k = 0; k < 2 * NB - 1; k++) begin
            int b, len, t;
            logic [NB*WB-1:0] d;
            b   = (k > NB - 1) ? k - NB + 1 : 0;
            len = (k + 1 < 2 * NB - 1 - k) ? k + 1 : 2 * NB - 1 - k;
            for (int j = 0; j < NB; j++)
                d[j*WB +: WB] = (j < len) ? 16'(elem(off_b, b + j, k - b - j)) : 16'hBEEF;
            ifb.in_data = d; ifb.in_valid = 1'b1; t = 0;
            do begin
                @(negedge clk);
                chk("B out_valid low in collect", ifb.out_valid, 0);
                t++;
            end while (!ifb.in_ready && t < 50);
            chk("B diagonal accepted", ifb.in_ready, 1);
            @(posedge clk); #1;
            ifb.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("B out_valid after last diagonal", ifb.out_valid, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; tr_a = 1'b0; start_b = 1'b0; tr_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.in_data = '0;
        off_a = 0; off_b = 0; mode_a = 0; cyc_a = 0;
        done_a = 0; done_b = 0; tr_model_a = 1'b0;
        #12;
        chk_idle_a();
        chk("B rst busy", busy_b, 0);
        chk("B rst out_valid", ifb.out_valid, 0);
        chk("B rst out_data nonzero", |ifb.out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Plain row order
        start_a_t(0);
        send_a(0, 0, -1, 2 * NA - 1);
        chk("pin A M[0][0]", ifa.out_data[31:0], 32'h101);
        chk("pin A M[0][3]", ifa.out_data[127:96], 32'h104);
        wait_done_a(0);

        // Transposed
        start_a_t(1);
        send_a(0, 0, -1, 2 * NA - 1);
        chk("pin A T beat0 lane1", ifa.out_data[63:32], 32'h201);
        chk("pin A T beat0 lane3", ifa.out_data[127:96], 32'h401);
        wait_done_a(0);

        // Input gaps and output stalls
        mode_a = 1;
        start_a_t(0);
        send_a(2, 0, -1, 2 * NA - 1);
        wait_done_a(0);
        mode_a = 0;

        // start pulses during COLLECT and DRAIN are ignored
        start_a_t(0);
        send_a(0, 0, 2, 2 * NA - 1);
        wait_done_a(1);

        // Garbage in unused lanes, transposed
        start_a_t(1);
        send_a(0, 1, -1, 2 * NA - 1);
        wait_done_a(0);

        // Reset mid-collection, then a fresh matrix with new contents
        start_a_t(0);
        send_a(0, 0, -1, 5);
        rst_n = 1'b0;
        #1;
        chk_idle_a();
        @(posedge clk); #1;
        rst_n = 1'b1;
        off_a = 32'h5000;
        start_a_t(0);
        send_a(0, 1, -1, 2 * NA - 1);
        chk("pin A post-reset M[0][0]", ifa.out_data[31:0], 32'h5101);
        wait_done_a(0);

        // N=8, W=16
        begin
            int d0, t;
            start_b = 1'b1;
            @(posedge clk); #1;
            start_b = 1'b0;
            chk("B busy after start", busy_b, 1);
            send_b();
            chk("pin B M[0][0]", ifb.out_data[15:0], 16'h101);
            chk("pin B M[0][7]", ifb.out_data[127:112], 16'h108);
            d0 = done_b; t = 0;
            while (done_b == d0 && t < 100) begin @(negedge clk); t++; end
            chk("B drain completes", done_b != d0, 1);
            @(posedge clk); #1;
            chk("B busy after drain", busy_b, 0);
            chk("B out_valid after drain", ifb.out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/diag_aggregator.md
Name: diag_aggregator

Overview:
Parametrised collector for systolic-array result wavefronts. Each input beat is one anti-diagonal of an N×N result matrix, packed into lanes. The block assembles the full matrix in a local buffer, then streams it out one row per beat under valid/ready. It sits between the PE array drain and the writeback path, replacing the fixed 4×4 count-driven collector with an explicit handshake and drain phase.

Parameters:
N, 4, matrix dimension (N≥2); lane count of in_data and out_data
W, 32, element width in bits
TRANSPOSE_EN, 0, 1 = honour the transpose input; 0 = tie transpose off internally

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; arms a new collection; accepted only in IDLE
transpose  in  1  sampled with an accepted start; 1 = stream columns instead of rows
in_valid  in  1  in_data holds the current diagonal
in_ready  out  1  high only in COLLECT
in_data  in  N*W  lane j at bits [j*W +: W]; only the first L(k) lanes are meaningful
out_valid  out  1  out_data holds a valid row
out_ready  in  1  downstream accepts the row
out_data  out  N*W  element c at bits [c*W +: W]
out_row  out  clog2(N)  index of the row (or column) presented
out_last  out  1  high with the final row beat
busy  out  1  high in COLLECT or DRAIN

Behaviour:
- Asynchronous reset (rst_n=0): state=IDLE; diag counter k=0; row counter=0; matrix buffer cleared to 0; in_ready, out_valid, out_last, busy, out_row and out_data are all 0. A reset mid-operation abandons the current matrix with no partial output.
- FSM states:
  - IDLE: start moves to COLLECT next cycle. Latch the transpose flag, clear k, set busy.
  - COLLECT: in_ready=1. Each in_valid&in_ready beat writes diagonal k, then k increments. The beat with k=2N-2 moves to DRAIN next cycle. in_valid=0 holds everything.
  - DRAIN: out_valid=1. Row r is presented. An out_valid&out_ready beat advances r. The beat with r=N-1 (out_last=1) returns to IDLE and clears busy.
- Diagonal mapping, k in 0..2N-2:
  - lane count L(k)=min(k+1, 2N-1-k)
  - row offset b(k)=max(0, k-N+1)
  - lane j<L(k) writes M[b+j][k-b-j]
  - lanes j≥L(k) are ignored; their contents are don't-care
- Output:
  - transpose=0: out_data element c = M[r][c].
  - transpose=1: out_data element c = M[c][r].
  - out_data, out_row and out_last are registered. They stay stable while out_valid&!out_ready (standard valid/ready; no combinational path from out_ready to out_valid).
- Latency: the cycle after the final diagonal beat, out_valid=1 with row 0. Back-to-back out_ready gives N consecutive beats, so the minimum total is 2N-1 input beats plus N output beats plus 1 cycle.
- start outside IDLE is ignored; it does not restart and is not queued. start and reset both asserted: reset wins.
- Buffer content is not cleared between matrices; every entry is overwritten by a complete collection.
- Width rules: elements pass through unmodified. The k counter is clog2(2N-1) bits and the row counter clog2(N) bits. Neither counter wraps past its terminal value.

Decomposition:
- Package diag_aggregator_pkg holds the state enum (IDLE, COLLECT, DRAIN) and the functions diag_len(k,N) and diag_base(k,N). These are shared with the PE-array drain sequencer.
- One sub-module, agg_diag_map: combinational. Given k, it produces a per-lane write-enable vector and the row/column index for each lane. The top level owns the FSM, counters, buffer and output registers.

Test Plan:
- N=4, W=32. Send start, then 7 diagonals where lane value = 0x100*(row+1)+(col+1). Example: diagonal k=3 lanes = 0x104, 0x203, 0x302, 0x401. Required: out_valid the cycle after the 7th beat; rows 0x101..0x104, 0x201..0x204, …; out_last on row 3; then IDLE.
- Same data with transpose=1 (TRANSPOSE_EN=1). Required: beat r carries column r, i.e. beat 0 = 0x101, 0x201, 0x301, 0x401.
- in_valid gaps (one beat every 3 cycles) and out_ready toggled 1,0,0,1. Required: identical matrix output; out_data and out_row held stable during stalls; in_ready=0 throughout DRAIN.
- start pulsed during COLLECT (after diagonal 2) and again during DRAIN. Required: no restart; k continues; output unchanged.
- Garbage (0xDEADBEEF) in unused lanes j≥L(k) for every diagonal. Required: output matrix is unaffected.
- rst_n pulsed low after diagonal 4. Required: all outputs 0 immediately and state IDLE. A new start plus a full 7-beat collection yields a correct matrix with no residue; N=8, W=16 variant passes the first scenario scaled (15 diagonals, 8 rows).
